mem_fill_arbiter: RTL and testbench



---
 rtl/mem_fill_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one multicycle memory port between I-cache fills, D-cache fills and D-cache write-through stores.
// Latency: grant one cycle after a request is seen in IDLE; block fill done pulse 12 cycles after grant; store acked 1 cycle after grant.
// Backpressure: requests are held levels; anything arriving while busy simply waits for the next IDLE cycle.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_miss_req/addr   : I-cache block miss (level) and byte address
//   d_miss_req/addr   : D-cache read miss (level) and byte address
//   d_wr_req/addr/data: D-side write-through store (level), byte address, data
//   mem_data_out/valid: memory read return path
//   mem_addr/enable/wr/data_in : memory request port
//   fill_data/fill_word, i_fill_we/d_fill_we : cache data-array write port
//   i_fill_done/d_fill_done/d_wr_ack : completion pulses back to requesters
//   busy              : arbiter not in IDLE
module mem_fill_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss_req,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss_req,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_data_in,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_ack,
  output logic        busy
);

  // The block geometry (3-bit word offset, 16-byte base mask) is hard-wired,
  // and the read counters assume the memory returns at least one cycle late.
  if (WORDS != 8 || MEM_LAT < 1) begin : g_param_check
    $error("mem_fill_arbiter: WORDS must be 8 and MEM_LAT must be >= 1");
  end

  localparam logic [3:0] LP_WORDS = 4'(WORDS);
  localparam logic [2:0] LP_LAST  = 3'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [3:0]  r_ic;
  logic [2:0]  r_rc;

  logic [15:0] w_addr_nxt;
  logic [15:0] w_wdata_nxt;
  logic [3:0]  w_ic_nxt;
  logic [2:0]  w_rc_nxt;

  logic        w_fill;
  logic        w_issue;
  logic        w_rx;
  logic        w_last;
  logic [15:0] w_base;

  assign w_fill  = (r_state == FILL_I) || (r_state == FILL_D);
  // Reads are issued back to back until the whole block has been requested;
  // returns are counted independently so issue and receive overlap.
  assign w_issue = w_fill && (r_ic < LP_WORDS);
  assign w_rx    = w_fill && mem_data_valid;
  assign w_last  = w_rx && (r_rc == LP_LAST);
  assign w_base  = r_addr & 16'hFFF0;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ic    <= '0;
      r_rc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_ic    <= w_ic_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next state: fixed priority store > D miss > I miss, decided only in IDLE
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_ic_nxt    = r_ic;
    w_rc_nxt    = r_rc;

    case (r_state)
      IDLE: begin
        if (d_wr_req) begin
          w_state_nxt = WRITE;
          w_addr_nxt  = d_wr_addr;
          w_wdata_nxt = d_wr_data;
          w_ic_nxt    = '0;
          w_rc_nxt    = '0;
        end else if (d_miss_req) begin
          w_state_nxt = FILL_D;
          w_addr_nxt  = d_miss_addr;
          w_ic_nxt    = '0;
          w_rc_nxt    = '0;
        end else if (i_miss_req) begin
          w_state_nxt = FILL_I;
          w_addr_nxt  = i_miss_addr;
          w_ic_nxt    = '0;
          w_rc_nxt    = '0;
        end
      end

      FILL_I, FILL_D: begin
        if (w_issue) begin
          w_ic_nxt = r_ic + 4'd1;
        end
        if (w_rx) begin
          w_rc_nxt = r_rc + 3'd1;
        end
        // A fill always runs to its last word, even if the request drops.
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end

      WRITE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs. Memory port and completion are state/counter derived; the
  // data-array write strobe follows mem_data_valid in the same cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_data_in = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    busy        = (r_state != IDLE);

    case (r_state)
      FILL_I, FILL_D: begin
        mem_enable = w_issue;
        if (w_issue) begin
          // Word offset is ic*2 bytes; at most 14 so the base never carries.
          mem_addr = w_base + {11'd0, r_ic, 1'b0};
        end
        fill_word = r_rc;
        if (w_rx) begin
          fill_data = mem_data_out;
        end
        if (r_state == FILL_I) begin
          i_fill_we   = w_rx;
          i_fill_done = w_last;
        end else begin
          d_fill_we   = w_rx;
          d_fill_done = w_last;
        end
      end

      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_addr;
        mem_data_in = r_wdata;
        d_wr_ack    = 1'b1;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed and random requests against a transaction-level model of the arbiter.
// Latency: memory model returns read data MEM_LAT cycles after the issue cycle.
// Backpressure: requesters hold their level requests until the model's done/ack cycle.
module tb_mem_fill_arbiter;

  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;
  localparam int FILL_LEN = WORDS + MEM_LAT;  // busy cycles of one block fill

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_req = 1'b0;
  logic [15:0] i_miss_addr = '0;
  logic        d_miss_req = 1'b0;
  logic [15:0] d_miss_addr = '0;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = '0;
  logic [15:0] d_wr_data = '0;
  logic [15:0] mem_data_out = '0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        d_wr_ack;
  logic        busy;

  always #5 clk = ~clk;

  mem_fill_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .busy(busy)
  );

  // Background memory contents: a salted hash of the word index.
  logic [15:0] salt = '0;

  function automatic logic [15:0] init_word(input logic [14:0] idx, input logic [15:0] s);
    logic [15:0] w;
    w = {idx, 1'b0};
    return (w * 16'h9E37) ^ s ^ {idx[7:0], idx[14:7]};
  endfunction

  // ---------------- memory device (driven by what the DUT actually does) ----
  logic [15:0] dev_mem [logic [14:0]];
  bit          iss_v = 1'b0;
  logic [15:0] iss_d = '0;
  bit          sh_v [1:MEM_LAT];
  logic [15:0] sh_d [1:MEM_LAT];

  always @(negedge clk) begin
    iss_v = mem_enable && !mem_wr;
    iss_d = dev_mem.exists(mem_addr[15:1]) ? dev_mem[mem_addr[15:1]] : init_word(mem_addr[15:1], salt);
    if (mem_enable && mem_wr) dev_mem[mem_addr[15:1]] = mem_data_in;
  end

  always @(posedge clk) begin
    #1;
    for (int k = MEM_LAT; k > 1; k--) begin
      sh_v[k] = sh_v[k-1];
      sh_d[k] = sh_d[k-1];
    end
    sh_v[1] = iss_v;
    sh_d[1] = iss_d;
    mem_data_valid = sh_v[MEM_LAT];
    mem_data_out   = sh_v[MEM_LAT] ? sh_d[MEM_LAT] : 16'(~salt);
  end

  // ---------------- reference model (transaction level) ----------------
  logic [15:0] ref_mem [logic [14:0]];
  int          m_kind = 0;  // 0 idle, 1 I fill, 2 D fill, 3 store
  int          m_t = 0;     // 1-based cycle within current transaction
  logic [15:0] m_base = '0;
  logic [15:0] m_waddr = '0;
  logic [15:0] m_wdata = '0;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] ref_word(input logic [14:0] idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx, salt);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move the model into the current cycle using the requests the DUT
  // sampled at the preceding clock edge.
  task automatic model_advance();
    if (rst) begin
      m_kind = 0;
      m_t    = 0;
    end else if (m_kind == 0) begin
      if (d_wr_req) begin
        m_kind = 3; m_waddr = d_wr_addr; m_wdata = d_wr_data; m_t = 1;
      end else if (d_miss_req) begin
        m_kind = 2; m_base = {d_miss_addr[15:4], 4'h0}; m_t = 1;
      end else if (i_miss_req) begin
        m_kind = 1; m_base = {i_miss_addr[15:4], 4'h0}; m_t = 1;
      end
    end else if ((m_kind == 3 && m_t == 1) || (m_kind != 3 && m_t == FILL_LEN)) begin
      m_kind = 0;
      m_t    = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic check_cycle();
    logic        e_en, e_wr, e_iwe, e_dwe, e_idone, e_ddone, e_ack, e_we;
    logic [15:0] e_addr, e_din, e_fd;
    logic [2:0]  e_word;
    int          w;
    e_en = 0; e_wr = 0; e_iwe = 0; e_dwe = 0; e_idone = 0; e_ddone = 0; e_ack = 0; e_we = 0;
    e_addr = '0; e_din = '0; e_fd = '0; e_word = '0;
    if (m_kind == 1 || m_kind == 2) begin
      if (m_t <= WORDS) begin
        e_en   = 1'b1;
        e_addr = m_base + 16'(2 * (m_t - 1));
      end
      if (m_t > MEM_LAT) begin
        w      = m_t - MEM_LAT - 1;
        e_we   = 1'b1;
        e_word = 3'(w);
        e_fd   = ref_word(m_base[15:1] + 15'(w));
        if (m_kind == 1) begin e_iwe = 1'b1; e_idone = (w == WORDS - 1); end
        else             begin e_dwe = 1'b1; e_ddone = (w == WORDS - 1); end
      end
    end else if (m_kind == 3) begin
      e_en = 1'b1; e_wr = 1'b1; e_addr = m_waddr; e_din = m_wdata; e_ack = 1'b1;
    end

    chk("mem_enable", mem_enable, e_en);
    chk("mem_wr", mem_wr, e_wr);
    chk("busy", busy, m_kind != 0);
    chk("i_fill_we", i_fill_we, e_iwe);
    chk("d_fill_we", d_fill_we, e_dwe);
    chk("i_fill_done", i_fill_done, e_idone);
    chk("d_fill_done", d_fill_done, e_ddone);
    chk("d_wr_ack", d_wr_ack, e_ack);
    if (e_en || m_kind == 0) chk("mem_addr", mem_addr, e_addr);
    if (e_wr || m_kind == 0) chk("mem_data_in", mem_data_in, e_din);
    if (e_we || m_kind == 0) chk("fill_data", fill_data, e_fd);
    if (e_we) chk("fill_word", fill_word, e_word);

    // Requesters drop their level once the model says the job is done.
    if (m_kind == 3) ref_mem[m_waddr[15:1]] = m_wdata;
    if (e_idone) i_miss_req = 1'b0;
    if (e_ddone) d_miss_req = 1'b0;
    if (e_ack)   d_wr_req   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_advance();
    check_cycle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0);
    chk({tag, "_mem_enable"}, mem_enable, 16'h0);
    chk({tag, "_mem_wr"}, mem_wr, 16'h0);
    chk({tag, "_mem_data_in"}, mem_data_in, 16'h0);
    chk({tag, "_fill_data"}, fill_data, 16'h0);
    chk({tag, "_fill_word"}, fill_word, 16'h0);
    chk({tag, "_i_fill_we"}, i_fill_we, 16'h0);
    chk({tag, "_d_fill_we"}, d_fill_we, 16'h0);
    chk({tag, "_i_fill_done"}, i_fill_done, 16'h0);
    chk({tag, "_d_fill_done"}, d_fill_done, 16'h0);
    chk({tag, "_d_wr_ack"}, d_wr_ack, 16'h0);
    chk({tag, "_busy"}, busy, 16'h0);
  endtask

  task automatic run_until_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while ((m_kind != 0 || i_miss_req || d_miss_req || d_wr_req) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_completes"}, n < budget, 1'b1);
  endtask

  initial begin
    int n;
    int stale;
    salt = 16'($urandom);

    // Reset state
    tick();
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // I miss at 0x1236: block 0x1230
    i_miss_addr = 16'h1236; i_miss_req = 1'b1;
    run_until_quiet("i_fill", 40);

    // D and I miss in the same cycle: D block 0x4000 first, then I block 0x0020
    d_miss_addr = 16'h4008; d_miss_req = 1'b1;
    i_miss_addr = 16'h0020; i_miss_req = 1'b1;
    run_until_quiet("d_then_i", 60);

    // Store and D miss together: store wins, D fill then reads the stored word back
    d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
    d_miss_addr = 16'h2008; d_miss_req = 1'b1;
    run_until_quiet("store_then_d", 60);

    // Store raised during an I fill waits for the fill to finish
    i_miss_addr = 16'h5550; i_miss_req = 1'b1;
    repeat (4) tick();
    d_wr_addr = 16'h5552; d_wr_data = 16'h1357; d_wr_req = 1'b1;
    run_until_quiet("store_waits", 60);

    // Reset in the middle of a fill, then stale returns must be ignored
    i_miss_addr = 16'h3A5C; i_miss_req = 1'b1;
    n = 0;
    while (!(m_kind == 1 && m_t == 6) && n < 30) begin
      tick();
      n++;
    end
    chk("rst_reach_fill6", n < 30, 1'b1);
    #2;
    rst = 1'b1;
    i_miss_req = 1'b0;
    #1;
    check_all_zero("rst_mid");
    m_kind = 0;
    m_t = 0;
    tick();
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      tick();
      if (mem_data_valid) stale++;
    end
    chk("stale_valid_seen", stale != 0, 1'b1);

    // Top-of-memory block: 0xFFF0..0xFFFE with no wrap
    d_miss_addr = 16'hFFFA; d_miss_req = 1'b1;
    run_until_quiet("top_block", 40);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      tick();
      if (!i_miss_req && $urandom_range(0, 9) == 0) begin
        i_miss_addr = 16'($urandom); i_miss_req = 1'b1;
      end
      if (!d_miss_req && $urandom_range(0, 9) == 0) begin
        d_miss_addr = 16'($urandom); d_miss_req = 1'b1;
      end
      if (!d_wr_req && $urandom_range(0, 7) == 0) begin
        d_wr_addr = 16'($urandom) & 16'hFFFE; d_wr_data = 16'($urandom); d_wr_req = 1'b1;
      end
    end
    run_until_quiet("random_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
